// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - LC-3 execute stage: ADD/AND/NOT single-cycle, optional shift-add MUL
//
// Captures the SR1/SR2 register-file operands (or sext(imm5) as B), produces
// Result and one-hot NZP condition codes, and uses a Start/Busy/Done
// handshake so the control FSM can sequence single- and multi-cycle ops alike.
//
// Build option: define ALU_MUL_EN to make ALUK=11 a WIDTH-cycle shift-add
// multiply. Without it, ALUK=11 is PASSA (Result <= A), single-cycle, and
// Busy is tied low.
//
// Ports:
//   Clk      in   rising-edge clock
//   Reset    in   synchronous, active-high
//   Start    in   operation request, accepted in IDLE or DONE
//   ALUK     in   00 ADD, 01 AND, 10 NOT(A), 11 MUL / PASSA
//   SR2MUX   in   1 = B is sext(IR_imm5), 0 = B is SR2_In
//   IR_imm5  in   immediate field
//   SR1_In   in   A operand
//   SR2_In   in   B operand
//   Busy     out  high while a multiply is in progress
//   Done     out  high for the single cycle after completion
//   Result   out  last completed result, held until the next completion
//   NZP      out  {N,Z,P} of Result, one-hot

module alu_exec #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ALUK,
  input  logic             SR2MUX,
  input  logic [4:0]       IR_imm5,
  input  logic [WIDTH-1:0] SR1_In,
  input  logic [WIDTH-1:0] SR2_In,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [2:0]       NZP
);

  logic [WIDTH-1:0] b_val;
  logic [WIDTH-1:0] single_res;

  assign b_val = SR2MUX ? {{(WIDTH-5){IR_imm5[4]}}, IR_imm5} : SR2_In;

  // Code 11 falls through to PASSA; in the multiply build the FSM never
  // takes this path for ALUK=11, so the default arm is harmless there.
  always_comb begin
    single_res = SR1_In;
    case (ALUK)
      2'b00:   single_res = SR1_In + b_val;
      2'b01:   single_res = SR1_In & b_val;
      2'b10:   single_res = ~SR1_In;
      default: single_res = SR1_In;
    endcase
  end

  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] r);
    if (r[WIDTH-1])
      return 3'b100;
    else if (r == '0)
      return 3'b010;
    else
      return 3'b001;
  endfunction

`ifdef ALU_MUL_EN

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_step;

  // Multiplicand shifts left each cycle, so bits shifted past WIDTH are
  // dropped: this yields exactly the low WIDTH bits of the product, which is
  // the same for signed and unsigned operands.
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= ST_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      Result <= '0;
      NZP    <= 3'b010;
    end else if (state == ST_MUL) begin
      // Start is deliberately not looked at here.
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) begin
        Result <= acc_step;
        NZP    <= nzp_of(acc_step);
        state  <= ST_DONE;
      end
    end else begin
      if (Start) begin
        if (ALUK == 2'b11) begin
          acc    <= '0;
          cnt    <= '0;
          mcand  <= SR1_In;
          mplier <= b_val;
          state  <= ST_MUL;
        end else begin
          Result <= single_res;
          NZP    <= nzp_of(single_res);
          state  <= ST_DONE;
        end
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  assign Busy = (state == ST_MUL);
  assign Done = (state == ST_DONE);

`else

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= ST_IDLE;
      Result <= '0;
      NZP    <= 3'b010;
    end else if (Start) begin
      Result <= single_res;
      NZP    <= nzp_of(single_res);
      state  <= ST_DONE;
    end else begin
      state <= ST_IDLE;
    end
  end

  assign Busy = 1'b0;
  assign Done = (state == ST_DONE);

`endif

endmodule
